// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle for muldiv_seq (start/op/a/b in; result/done/busy/stall/div0 out)
interface muldiv_if #(parameter int WIDTH = 32);
  logic start;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, result;
  logic done, busy, stall, div0;
  modport master(output start, op, a, b, input result, done, busy, stall, div0);
  modport slave(input start, op, a, b, output result, done, busy, stall, div0);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add MUL / restoring SDIV,UDIV; ports clk, reset, bus (start/op/a/b -> result/done/busy/stall/div0)
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DIV0_VAL = {WIDTH{1'b1}}
) (
  input logic clk,
  input logic reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] x, y, acc, q, mul_acc, rem_sh, rem_n, q_n, fin, res_r;
  logic is_mul, neg_q, dz, ge, valid, sdiv, last, done_r, div0_r;
  always_comb begin
    valid = bus.op inside {3'b100, 3'b101, 3'b110};
    sdiv = bus.op == 3'b100;
    last = count == CW'(WIDTH - 1);
    mul_acc = acc + (y[0] ? x : '0);
    rem_sh = {acc[WIDTH-2:0], x[WIDTH-1]};
    ge = rem_sh >= y;
    rem_n = ge ? rem_sh - y : rem_sh;
    q_n = {q[WIDTH-2:0], ge};
    fin = is_mul ? mul_acc : dz ? DIV0_VAL : neg_q ? -q_n : q_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      res_r <= '0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
      x <= '0;
      y <= '0;
      acc <= '0;
      q <= '0;
      is_mul <= 1'b0;
      neg_q <= 1'b0;
      dz <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start && valid) begin
          state <= RUN;
          count <= '0;
          div0_r <= 1'b0;
          is_mul <= bus.op == 3'b110;
          x <= (sdiv && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          y <= (sdiv && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          neg_q <= sdiv && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          dz <= bus.op != 3'b110 && bus.b == '0;
          acc <= '0;
          q <= '0;
        end
        RUN: begin
          x <= x << 1;
          acc <= is_mul ? mul_acc : rem_n;
          y <= is_mul ? y >> 1 : y;
          q <= is_mul ? q : q_n;
          if (last) begin
            state <= DONE;
            done_r <= 1'b1;
            res_r <= fin;
            div0_r <= dz;
          end else count <= count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.result = res_r;
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.busy = state != IDLE;
  assign bus.stall = (state == IDLE && bus.start && valid) || state == RUN;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  muldiv_if #(.WIDTH(32)) bus();
  muldiv_seq #(.WIDTH(32), .DIV0_VAL(32'hFFFFFFFF)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p;
    if (o == 3'b110) begin
      p = x * y;
      return {1'b0, p};
    end
    if (y == 32'd0) return {1'b1, 32'hFFFFFFFF};
    if (o == 3'b101) return {1'b0, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {1'b0, 32'h80000000};
    p = 32'($signed(x) / $signed(y));
    return {1'b0, p};
  endfunction
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int reissue);
    logic [32:0] e;
    int cyc, high;
    e = model(o, x, y);
    cyc = 1;
    high = 0;
    @(negedge clk);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    #1;
    if (bus.stall) high++;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
      if (bus.stall) high++;
      bus.start = cyc == reissue;
      bus.op = cyc == reissue ? 3'b101 : 3'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
    end
    bus.start = 1'b0;
    check("latency", 32'(cyc), 32'd34);
    check("stall_cycles", 32'(high), 32'd33);
    check("result", bus.result, e[31:0]);
    check("div0", 32'(bus.div0), 32'(e[32]));
    check("done_stall", 32'(bus.stall), 32'd0);
    check("done_busy", 32'(bus.busy), 32'd1);
  endtask
  initial begin
    int seen;
    logic [2:0] o;
    logic [31:0] x, y;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_div0", 32'(bus.div0), 32'd0);
    reset = 1'b0;
    do_op(3'b101, 32'd100, 32'd7, 0);
    do_op(3'b100, 32'hFFFFFF9C, 32'd7, 0);
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'b110, 32'h0000FFFF, 32'h00010001, 0);
    do_op(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'b101, 32'd5, 32'd0, 0);
    do_op(3'b110, 32'd3, 32'd4, 0);
    do_op(3'b110, 32'd3, 32'd4, 10);
    @(negedge clk);
    check("post_done", 32'(bus.done), 32'd0);
    bus.start = 1'b1;
    bus.op = 3'b010;
    #1;
    check("bad_op_stall", 32'(bus.stall), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done || bus.busy) seen++;
    end
    check("bad_op_quiet", 32'(seen), 32'd0);
    bus.start = 1'b1;
    bus.op = 3'b101;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    repeat (14) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("mid_rst_nodone", 32'(seen), 32'd0);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(4, 6));
      x = $urandom_range(0, 3) == 0 ? -32'($urandom_range(0, 500)) : $urandom;
      y = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom_range(0, 1) == 0 ? -32'($urandom_range(1, 20)) : $urandom;
      do_op(o, x, y, $urandom_range(0, 1) == 0 ? int'($urandom_range(3, 30)) : 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
